// File: rtl/serial_byte_adder_ctrl_pkg.sv
// sbadd_pkg: definitions shared by the serial byte adder controller,
// its bus interface and the 8-bit adder slice.
//   BYTE_W : width of one adder slice (one operand byte)
//   state_e: sequencer states IDLE / RUN / DONE, 2-bit encoding
//   idx_w(): width of the byte index for a given byte count, never below 1
package sbadd_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // clog2 of the byte count, but at least one bit so a single-byte build
   // still has a legal index register.
   function automatic int idx_w(input int nbytes);
      return (nbytes <= 1) ? 1 : $clog2(nbytes);
   endfunction

endpackage

// File: rtl/serial_byte_adder_ctrl_if.sv
// serial_byte_adder_ctrl_if: requester <-> sequencer bus.
//   start, a, b, cin : request and operands (requester drives)
//   sub              : subtract select, present only with SBADD_SUB_EN
//   busy, done       : status (sequencer drives)
//   sum, cout        : result (sequencer drives)
// Modports: master = requester side, slave = sequencer side.
interface serial_byte_adder_ctrl_if #(
   parameter int NBYTES = 4
);
   localparam int W = sbadd_pkg::BYTE_W * NBYTES;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef SBADD_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

`ifdef SBADD_SUB_EN
   modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_byte_adder_ctrl_adder8_slice.sv
// adder8_slice: purely combinational 8-bit ripple-carry adder.
//   a8, b8 : operand bytes
//   ci     : carry in
//   s8     : sum byte
//   co     : carry out
module adder8_slice
   import sbadd_pkg::*;
(
   input  logic [BYTE_W-1:0] a8,
   input  logic [BYTE_W-1:0] b8,
   input  logic              ci,
   output logic [BYTE_W-1:0] s8,
   output logic              co
);

   logic [BYTE_W:0] c;

   always_comb begin
      c  = '0;
      s8 = '0;
      c[0] = ci;
      for (int i = 0; i < BYTE_W; i++) begin
         s8[i]   = a8[i] ^ b8[i] ^ c[i];
         c[i+1]  = (a8[i] & b8[i]) | (c[i] & (a8[i] ^ b8[i]));
      end
      co = c[BYTE_W];
   end

endmodule

// File: rtl/serial_byte_adder_ctrl.sv
// serial_byte_adder_ctrl: NBYTES-wide add done one byte per clock through a
// single shared 8-bit adder slice, least significant byte first, with the
// carry chained through a register.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_byte_adder_ctrl_if.slave (start/a/b/cin[/sub] in,
//         busy/done/sum/cout out)
// Optional macro SBADD_SUB_EN: adds bus.sub; sub=1 computes a + ~b + 1
// (cin ignored, cout=1 means no borrow).
module serial_byte_adder_ctrl
   import sbadd_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   serial_byte_adder_ctrl_if.slave bus
);

   localparam int IW = idx_w(NBYTES);

   state_e                           state_q, state_d;
   logic [IW-1:0]                    idx_q, idx_d;
   logic                             carry_q, carry_d;
   logic [NBYTES-1:0][BYTE_W-1:0]    a_q, a_d;
   logic [NBYTES-1:0][BYTE_W-1:0]    b_q, b_d;
   logic [NBYTES-1:0][BYTE_W-1:0]    sum_q, sum_d;
   logic                             cout_q, cout_d;
`ifdef SBADD_SUB_EN
   logic                             sub_q, sub_d;
`endif

   logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
   logic              c_out;

   // Byte mux in front of the shared slice.
   assign a_byte = a_q[idx_q];
`ifdef SBADD_SUB_EN
   assign b_byte = sub_q ? ~b_q[idx_q] : b_q[idx_q];
`else
   assign b_byte = b_q[idx_q];
`endif

   adder8_slice u_slice (
      .a8 (a_byte),
      .b8 (b_byte),
      .ci (carry_q),
      .s8 (s_byte),
      .co (c_out)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SBADD_SUB_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            // DONE accepts a new request exactly like IDLE so that
            // back-to-back issue costs no extra cycle.
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
`ifdef SBADD_SUB_EN
               sub_d   = bus.sub;
               carry_d = bus.sub ? 1'b1 : bus.cin;
`else
               carry_d = bus.cin;
`endif
               sum_d   = '0;
               cout_d  = 1'b0;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[idx_q] = s_byte;
            carry_d      = c_out;
            if (idx_q == IW'(NBYTES - 1)) begin
               cout_d  = c_out;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SBADD_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SBADD_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_byte_adder_ctrl.sv
// Bench for serial_byte_adder_ctrl (NBYTES=4): directed vectors with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_serial_byte_adder_ctrl;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_byte_adder_ctrl_if #(.NBYTES(NB)) bus ();

   serial_byte_adder_ctrl #(.NBYTES(NB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic sub_in;
`ifdef SBADD_SUB_EN
   assign sub_in = bus.sub;
`else
   assign sub_in = 1'b0;
`endif

   function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
      if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
      return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
   endfunction

   int           run_left = 0;   // cycles of computation still to go
   logic         done_exp = 1'b0;
   logic [W:0]   pend     = '0;
   logic [W-1:0] res_sum  = '0;
   logic         res_cout = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         run_left <= 0;
         done_exp <= 1'b0;
         res_sum  <= '0;
         res_cout <= 1'b0;
      end else if (run_left == 0 && bus.start) begin
         pend     <= model_add(bus.a, bus.b, bus.cin, sub_in);
         run_left <= NB;
         done_exp <= 1'b0;
         res_sum  <= '0;
         res_cout <= 1'b0;
      end else if (run_left > 0) begin
         run_left <= run_left - 1;
         done_exp <= (run_left == 1);
         if (run_left == 1) begin
            res_sum  <= pend[W-1:0];
            res_cout <= pend[W];
         end
      end else begin
         done_exp <= 1'b0;
      end
   end

   logic cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_busy", bus.busy, run_left > 0);
         chk("m_done", bus.done, done_exp);
         if (run_left == 0) begin
            chk("m_sum", bus.sum, res_sum);
            chk("m_cout", bus.cout, res_cout);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Called at a negedge; issues one request and waits for its done pulse.
   task automatic issue(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic [W-1:0] exp_sum, input logic exp_cout);
      int lat;
      lat = 0;
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      bus.cin   = ci;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      chk({name, "_lat"}, lat, NB + 1);
      chk({name, "_sum"}, bus.sum, exp_sum);
      chk({name, "_cout"}, bus.cout, exp_cout);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n, k1, k2;
      logic [W-1:0] s1, s2;
      logic c1, c2;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
`ifdef SBADD_SUB_EN
      bus.sub = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_cout", bus.cout, 0);
      cmp_en = 1'b1;
      rst = 1'b0;
      @(negedge clk);

      // 1, 2: basic add, full carry ripple
      issue("t1", 32'h000000F0, 32'h000000FF, 1'b1, 32'h000001F0, 1'b0);
      issue("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);

      // 3: start while busy is ignored
      bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.cin = 1'b0;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk); bus.start = 1'b1; bus.a = 32'd5;
      @(negedge clk); bus.start = 1'b0;
      n = 0; s1 = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done) begin n++; s1 = bus.sum; end
      end
      chk("t3_pulses", n, 1);
      chk("t3_sum", s1, 32'h00000002);

      // 4: reset mid-run aborts without done
      bus.start = 1'b1; bus.a = 32'h12345678; bus.b = 32'h11111111; bus.cin = 1'b0;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("t4_busy", bus.busy, 0);
      chk("t4_done", bus.done, 0);
      chk("t4_sum", bus.sum, 0);
      chk("t4_cout", bus.cout, 0);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done) n++;
      end
      chk("t4_nodone", n, 0);
      issue("t4b", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);

      // 5: start held across DONE gives back-to-back operations
      bus.start = 1'b1; bus.a = 32'h80000000; bus.b = 32'h80000000; bus.cin = 1'b0;
      n = 0; k1 = 0; k2 = 0; s1 = '1; s2 = '1; c1 = 1'b0; c2 = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (bus.done) begin
            n++;
            if (n == 1) begin k1 = k; s1 = bus.sum; c1 = bus.cout; end
            else begin k2 = k; s2 = bus.sum; c2 = bus.cout; bus.start = 1'b0; end
         end
      end
      bus.start = 1'b0;
      chk("t5_pulses", n, 2);
      chk("t5_first", k1, 5);
      chk("t5_gap", k2 - k1, 5);
      chk("t5_sum1", s1, 32'h0);
      chk("t5_cout1", c1, 1'b1);
      chk("t5_sum2", s2, 32'h0);
      chk("t5_cout2", c2, 1'b1);
      repeat (2) @(negedge clk);

`ifdef SBADD_SUB_EN
      // 6: subtract mode
      bus.sub = 1'b1;
      issue("t6a", 32'h00000010, 32'h00000020, 1'b0, 32'hFFFFFFF0, 1'b0);
      issue("t6b", 32'h00000020, 32'h00000010, 1'b0, 32'h00000010, 1'b1);
      bus.sub = 1'b0;
      issue("t6c", 32'h00000020, 32'h00000010, 1'b1, 32'h00000031, 1'b0);
`endif

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
